// File: rtl/img_proc_pkg.sv
// Shared types for the Bayer image-processing path: quad sample bundle and framing states.
package img_proc_pkg;

    localparam int unsigned BAYER_W = 12;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        WAIT
    } quad_state_t;

    typedef struct packed {
        logic [BAYER_W-1:0] g1;
        logic [BAYER_W-1:0] r;
        logic [BAYER_W-1:0] b;
        logic [BAYER_W-1:0] g2;
    } quad_t;

endpackage

// File: rtl/quad_sum.sv
// Registered stage-1 combiner: folds a 2x2 Bayer quad into a 16-bit pixel word.
// RGB565_EN selects RGB565 packing; otherwise the word is 12-bit gray, zero-extended.
module quad_sum
    import img_proc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        eof_i,
    input  quad_t       quad_i,
    output logic        valid_o,
    output logic        eof_o,
    output logic [15:0] pix_o
);

`ifdef RGB565_EN
    logic [BAYER_W:0] gsum;
    logic [15:0]      rgb_q;

    assign gsum = {1'b0, quad_i.g1} + {1'b0, quad_i.g2};

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_q <= '0;
        end else if (valid_i) begin
            rgb_q <= {5'(quad_i.r >> 7), 6'(gsum >> 7), 5'(quad_i.b >> 7)};
        end
    end

    assign pix_o = rgb_q;
`else
    logic [BAYER_W+1:0] sum;
    logic [BAYER_W+1:0] sum_q;

    // 14 bits hold four full-scale samples without overflow.
    assign sum = 14'(quad_i.g1) + 14'(quad_i.r) + 14'(quad_i.b) + 14'(quad_i.g2);

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= '0;
        end else if (valid_i) begin
            sum_q <= sum;
        end
    end

    assign pix_o = 16'(sum_q >> 2);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o <= 1'b0;
            eof_o   <= 1'b0;
        end else begin
            valid_o <= valid_i;
            eof_o   <= valid_i && eof_i;
        end
    end

endmodule

// File: rtl/bayer_quad_gray.sv
// Collapses each G R / B G Bayer quad into one half-resolution pixel with frame sync and
// EOL/EOF flags. Define RGB565_EN for RGB565 output instead of 12-bit gray.
module bayer_quad_gray
    import img_proc_pkg::*;
#(
    parameter int unsigned IMG_W = 1280,
    parameter int unsigned IMG_H = 960
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               iDVAL,
    input  logic [BAYER_W-1:0] iTAP0,
    input  logic [BAYER_W-1:0] iTAP1,
    input  logic [11:0]        iX_Cont,
    input  logic [15:0]        iY_Cont,
    output logic [15:0]        oDATA,
    output logic               oVAL,
    output logic               oEOL,
    output logic               oEOF,
    output logic [10:0]        oX,
    output logic [14:0]        oY,
    output logic               oSYNCED
);

    localparam logic [11:0] LAST_X  = 12'(IMG_W - 1);
    localparam logic [15:0] LAST_Y  = 16'(IMG_H - 1);
    localparam logic [10:0] LAST_OX = 11'(IMG_W / 2 - 1);
    localparam logic [14:0] LAST_OY = 15'(IMG_H / 2 - 1);

    quad_state_t        state_q;
    logic [BAYER_W-1:0] p0_q, p1_q;
    logic [10:0]        col_q;
    logic [14:0]        row_q;
    logic               sof, quad_done, quad_acc, quad_last, col_last;
    quad_t              quad;
    logic               s1_valid, s1_eof;
    logic [15:0]        s1_pix;

    assign sof       = iDVAL && (iX_Cont == '0) && (iY_Cont == '0);
    assign quad_done = iDVAL && iX_Cont[0] && iY_Cont[0];
    assign quad_acc  = quad_done && (state_q == ACTIVE);
    assign quad_last = (iX_Cont == LAST_X) && (iY_Cont == LAST_Y);
    assign quad      = '{g1: p0_q, r: iTAP0, b: p1_q, g2: iTAP1};
    assign col_last  = (col_q == LAST_OX);
    assign oSYNCED   = (state_q == ACTIVE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            unique case (state_q)
                IDLE, WAIT: if (sof) state_q <= ACTIVE;
                ACTIVE:     if (quad_acc && quad_last) state_q <= WAIT;
                default:    state_q <= IDLE;
            endcase
        end
    end

    // Left-column samples persist across iDVAL gaps until the odd column arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            p0_q <= '0;
            p1_q <= '0;
        end else if (iDVAL) begin
            p0_q <= iTAP0;
            p1_q <= iTAP1;
        end
    end

    quad_sum u_quad_sum (
        .clk     (clk),
        .rst     (rst),
        .valid_i (quad_acc),
        .eof_i   (quad_last),
        .quad_i  (quad),
        .valid_o (s1_valid),
        .eof_o   (s1_eof),
        .pix_o   (s1_pix)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            oDATA <= '0;
            oVAL  <= 1'b0;
            oEOL  <= 1'b0;
            oEOF  <= 1'b0;
            oX    <= '0;
            oY    <= '0;
            col_q <= '0;
            row_q <= '0;
        end else begin
            oVAL <= s1_valid;
            oEOL <= s1_valid && col_last;
            oEOF <= s1_valid && s1_eof;
            if (s1_valid) begin
                oDATA <= s1_pix;
                oX    <= col_q;
                oY    <= row_q;
            end
            // A frame start clears the counters; an in-flight pixel keeps its old coordinates.
            if (sof) begin
                col_q <= '0;
                row_q <= '0;
            end else if (s1_valid) begin
                col_q <= (s1_eof || col_last) ? '0 : col_q + 11'd1;
                if (s1_eof) begin
                    row_q <= '0;
                end else if (col_last) begin
                    row_q <= (row_q == LAST_OY) ? '0 : row_q + 15'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bayer_quad_gray.sv
// Scoreboard bench for bayer_quad_gray on a 4x4 frame; honours RGB565_EN for expected data.
module tb_bayer_quad_gray;

`ifdef RGB565_EN
    localparam logic [15:0] EXP_Q   = 16'h0862;
    localparam logic [15:0] EXP_MAX = 16'hFFFF;
    localparam logic [15:0] EXP_GAP = 16'h4298;
`else
    localparam logic [15:0] EXP_Q   = 16'h00FA;
    localparam logic [15:0] EXP_MAX = 16'h0FFF;
    localparam logic [15:0] EXP_GAP = 16'h0680;
`endif

    typedef struct {
        logic [15:0] data;
        logic [10:0] x;
        logic [14:0] y;
        logic        eol;
        logic        eof;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iDVAL = 1'b0;
    logic [11:0] iTAP0 = '0, iTAP1 = '0, iX_Cont = '0;
    logic [15:0] iY_Cont = '0;
    logic [15:0] oDATA;
    logic        oVAL, oEOL, oEOF, oSYNCED;
    logic [10:0] oX;
    logic [14:0] oY;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    exp_t exp_q[$];

    bayer_quad_gray #(.IMG_W(4), .IMG_H(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .iDVAL   (iDVAL),
        .iTAP0   (iTAP0),
        .iTAP1   (iTAP1),
        .iX_Cont (iX_Cont),
        .iY_Cont (iY_Cont),
        .oDATA   (oDATA),
        .oVAL    (oVAL),
        .oEOL    (oEOL),
        .oEOF    (oEOF),
        .oX      (oX),
        .oY      (oY),
        .oSYNCED (oSYNCED)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic beat(input int x, input int y, input logic [11:0] t0, input logic [11:0] t1);
        @(posedge clk);
        #1;
        iDVAL   = 1'b1;
        iX_Cont = 12'(x);
        iY_Cont = 16'(y);
        iTAP0   = t0;
        iTAP1   = t1;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            iDVAL = 1'b0;
        end
    endtask

    task automatic expect_px(input logic [15:0] d, input int x, input int y,
                             input logic eol, input logic eof);
        exp_t e;
        e.data = d;
        e.x    = 11'(x);
        e.y    = 15'(y);
        e.eol  = eol;
        e.eof  = eof;
        e.cyc  = cyc + 2;
        exp_q.push_back(e);
    endtask

    task automatic frame(input logic [11:0] g1, input logic [11:0] r, input logic [11:0] b,
                         input logic [11:0] g2, input logic [15:0] d);
        for (int y = 0; y < 4; y++) begin
            for (int x = 0; x < 4; x++) begin
                if (y[0]) beat(x, y, x[0] ? r : g1, x[0] ? g2 : b);
                else      beat(x, y, 12'h5A5, 12'h3C3);
                if (x[0] && y[0]) expect_px(d, x / 2, y / 2, x == 3, (x == 3) && (y == 3));
                if (x == 1 && y == 0) begin
                    @(negedge clk);
                    check("synced_after_sof", 32'(oSYNCED), 32'd1);
                end
            end
        end
    endtask

    // Monitor: every oVAL pops one expectation, including the cycle it was due.
    always @(negedge clk) begin
        if (oVAL) begin
            if (exp_q.size() == 0) begin
                check("unexpected_oval", 32'(oDATA), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("odata", 32'(oDATA), 32'(e.data));
                check("ox", 32'(oX), 32'(e.x));
                check("oy", 32'(oY), 32'(e.y));
                check("oeol", 32'(oEOL), 32'(e.eol));
                check("oeof", 32'(oEOF), 32'(e.eof));
                check("latency_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_oval", 32'(oVAL), 32'd0);
        check("rst_synced", 32'(oSYNCED), 32'd0);
        check("rst_odata", 32'(oDATA), 32'd0);

        // Stray quads before the first frame start are dropped
        beat(1, 1, 12'd7, 12'd8);
        beat(2, 1, 12'd9, 12'd10);
        beat(3, 1, 12'd11, 12'd12);
        gap(3);
        @(negedge clk);
        check("idle_synced", 32'(oSYNCED), 32'd0);

        // Full frame of identical quads
        frame(12'd100, 12'd200, 12'd300, 12'd400, EXP_Q);
        gap(3);
        @(negedge clk);
        check("wait_synced", 32'(oSYNCED), 32'd0);

        // Quads in WAIT are dropped
        beat(1, 1, 12'd1, 12'd2);
        beat(3, 1, 12'd3, 12'd4);
        gap(2);

        // Full-scale samples
        frame(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, EXP_MAX);
        gap(2);

        // iDVAL gap inside a quad, then a mid-frame restart
        for (int x = 0; x < 4; x++) beat(x, 0, 12'h111, 12'h222);
        beat(0, 1, 12'h800, 12'hC00);
        gap(3);
        beat(1, 1, 12'h400, 12'h200);
        expect_px(EXP_GAP, 0, 0, 1'b0, 1'b0);
        beat(2, 1, 12'h800, 12'hC00);
        beat(3, 1, 12'h400, 12'h200);
        expect_px(EXP_GAP, 1, 0, 1'b1, 1'b0);
        for (int x = 0; x < 4; x++) beat(x, 2, 12'h111, 12'h222);
        beat(0, 3, 12'h800, 12'hC00);
        beat(1, 3, 12'h400, 12'h200);
        expect_px(EXP_GAP, 0, 1, 1'b0, 1'b0);
        beat(0, 0, 12'h111, 12'h222);
        for (int x = 1; x < 4; x++) beat(x, 0, 12'h111, 12'h222);
        beat(0, 1, 12'h800, 12'hC00);
        beat(1, 1, 12'h400, 12'h200);
        expect_px(EXP_GAP, 0, 0, 1'b0, 1'b0);
        gap(3);
        @(negedge clk);
        check("restart_synced", 32'(oSYNCED), 32'd1);

        // Reset one cycle after a quad completes kills it
        beat(2, 1, 12'h800, 12'hC00);
        beat(3, 1, 12'h400, 12'h200);
        @(posedge clk);
        #1;
        iDVAL = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst2_oval", 32'(oVAL), 32'd0);
        check("rst2_odata", 32'(oDATA), 32'd0);
        check("rst2_eol_eof", 32'({oEOL, oEOF}), 32'd0);
        check("rst2_xy", 32'({oX, oY}), 32'd0);
        check("rst2_synced", 32'(oSYNCED), 32'd0);
        beat(1, 1, 12'd5, 12'd6);
        beat(3, 1, 12'd5, 12'd6);
        gap(4);

        // Drain, bounded
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        check("pending_expectations", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bayer_quad_gray.md
# bayer_quad_gray

Downstream stage of the Bayer line-buffer pair in the image-processing path. It consumes the two row taps (upper row, current row) together with the capture coordinates and collapses each 2x2 Bayer quad (G R / B G) into one half-resolution output pixel. The pixel is either 12-bit gray or RGB565, and is presented in the format the SDRAM write FIFO (`WR1_DATA`/`WR1`) expects. It also frames the stream so that stray beats before the first frame start are discarded, and it flags end-of-line and end-of-frame.

## Interface
**Parameters**
- `IMG_W`, default 1280: sensor line width in pixels; must be even.
- `IMG_H`, default 960: sensor frame height in lines; must be even.

**Ports**
- `clk`: input, 1 bit. Pixel clock; also clocks the line buffer.
- `rst`: input, 1 bit. Reset, synchronous and active-high.
- `iDVAL`: input, 1 bit. Valid beat; the same signal as the line buffer `clken`.
- `iTAP0`: input, 12 bits. Upper-row sample (line buffer `taps1x`).
- `iTAP1`: input, 12 bits. Current-row sample (line buffer `taps0x`).
- `iX_Cont`: input, 12 bits. Column of the current beat, range 0..IMG_W-1.
- `iY_Cont`: input, 16 bits. Row of the current beat, range 0..IMG_H-1.
- `oDATA`: output, 16 bits. Output pixel, going to `WR1_DATA`.
- `oVAL`: output, 1 bit. Output pixel valid, going to `WR1`.
- `oEOL`: output, 1 bit. Asserted together with `oVAL` on the last pixel of an output line.
- `oEOF`: output, 1 bit. Asserted together with `oVAL` on the last pixel of a frame.
- `oX`: output, 11 bits. Output column, range 0..IMG_W/2-1.
- `oY`: output, 15 bits. Output row, range 0..IMG_H/2-1.
- `oSYNCED`: output, 1 bit. High while the block is in state ACTIVE.

## Operation
**Sample capture**
- On every beat with `iDVAL` high, the block registers `iTAP0` into `p0` and `iTAP1` into `p1`.
- A quad completes on a beat with `iDVAL` high, `iX_Cont[0]==1` and `iY_Cont[0]==1`. The four samples are:
  - G1 = `p0` (top-left)
  - R = `iTAP0` (top-right)
  - B = `p1` (bottom-left)
  - G2 = `iTAP1` (bottom-right)

**State machine**
- IDLE is the reset state. Every beat is ignored except a beat with `iDVAL` high, `iX_Cont==0` and `iY_Cont==0`, which moves the block to ACTIVE.
- ACTIVE: each completed quad enters the pipeline.
  - The last quad of a frame is at `iX_Cont==IMG_W-1` and `iY_Cont==IMG_H-1`. It emits with `oEOF` high and returns the block to WAIT.
- WAIT: the block discards beats until the next (0,0) beat, then moves to ACTIVE on that cycle.
- A (0,0) beat seen while ACTIVE is a restart. The block stays in ACTIVE and clears the output column and row counters. Any quad already in the pipeline still emits.

**Arithmetic**
- Sums use 14 bits: gray = (G1+R+B+G2) >> 2, truncated, which gives 12 bits.
- gsum = G1+G2 uses 13 bits. G6 = gsum[12:7].
- Gray output: `oDATA = {4'b0, gray}`.

**Output coordinates**
- `oX` increments on each `oVAL` and wraps to 0 after IMG_W/2-1. `oEOL` is high on that wrapping pixel.
- `oY` increments on each `oEOL` and wraps to 0 together with `oEOF`.

**Reset**
- Reset clears the pipeline at any point, including mid-frame. No `oVAL` is produced for a quad that was in flight when `rst` was asserted.

## Timing
- Reset values: `oDATA`=0, `oVAL`=0, `oEOL`=0, `oEOF`=0, `oX`=0, `oY`=0, `oSYNCED`=0; state is IDLE.
- The pipeline has 2 stages:
  - Stage 1 registers the sums.
  - Stage 2 registers `oDATA`, `oVAL` and the flags.
- Latency: a quad completing at cycle t gives `oVAL` high at cycle t+2 for exactly 1 cycle.
- There is no backpressure; the downstream FIFO must always accept. With a full-rate `iDVAL`, output occurs at most once every 2 cycles.
- Gaps in `iDVAL` hold `p0`/`p1` and do not break a quad.

## Configuration
- `RGB565_EN` defined: `oDATA = {R[11:7], G6, B[11:7]}`, the RGB565 packing. The 14-bit gray adder is removed.
- `RGB565_EN` undefined: the block produces gray output as described under Operation.

## Structure
Package `img_proc_pkg` holds:
- the state enum `quad_state_t` (IDLE, ACTIVE, WAIT);
- the `BAYER_W=12` constant;
- the `quad_t` struct {g1, r, b, g2}.

One sub-module, `quad_sum`, is the registered stage-1 combiner. It contains the gray or RGB565 arithmetic selected by the macro.

## Test plan
1. Reset then one frame with IMG_W=4, IMG_H=4 and every quad {G1=100, R=200, B=300, G2=400} → 4 `oVAL` pulses, each with `oDATA`=0x00FA. `oEOF` is high on the 4th pulse only.
2. Beats before the first (0,0) beat → no `oVAL`, `oSYNCED`=0; `oSYNCED`=1 on the cycle after (0,0).
3. Quad with all samples = 0xFFF → gray output 0x0FFF, no overflow. With `RGB565_EN`: output 0xFFFF.
4. `iDVAL` low for 3 cycles between the even and odd columns of a quad → the same `oDATA` as the gapless case; `oVAL` follows the odd beat by exactly 2 cycles.
5. `rst` pulsed 1 cycle after a quad completes → no `oVAL`; all outputs are 0; state IDLE.
6. (0,0) beat mid-frame → `oX`/`oY` return to 0; the next quad emits with `oX`=0, `oY`=0.
